tt_um_serial_deserializer: RTL and testbench

TT_UM_SERIAL_DESERIALIZER -- requirements
Module: tt_um_serial_deserializer

---
 rtl/usd_pkg.sv | 27 ++
 rtl/sync2.sv | 23 ++
 rtl/tt_um_serial_deserializer.sv | 161 ++++++++++++++++
 tb/tb_tt_um_serial_deserializer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/usd_pkg.sv
// Shared constants for the serial deserializer:
// FIFO depth, data width, pin bit indices, shift direction.
package usd_pkg;

  localparam int DEPTH = 2;
  localparam int DW    = 8;

  localparam int UI_SDATA   = 0;
  localparam int UI_SSTROBE = 1;
  localparam int UI_DIR     = 2;
  localparam int UI_PAR_EN  = 3;
  localparam int UI_PAR_ODD = 4;
  localparam int UI_RD_ACK  = 5;
  localparam int UI_CLR     = 6;
  localparam int UI_SFRAME  = 7;

  localparam int UO_VALID     = 0;
  localparam int UO_FULL      = 1;
  localparam int UO_PAR_ERR   = 2;
  localparam int UO_OVERRUN   = 3;
  localparam int UO_FRAME_ERR = 4;
  localparam int UO_BIT_CNT   = 5;

  localparam logic DIR_MSB = 1'b0;
  localparam logic DIR_LSB = 1'b1;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous input bit.
// Runs independently of ena so inputs stay fresh.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tt_um_serial_deserializer.sv
// Strobed serial-to-parallel receiver with optional parity,
// framing check and a 2-entry output FIFO.
module tt_um_serial_deserializer
  import usd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] CNT_FULL = 2'(DEPTH);

  logic [7:0]    s;
  logic          stb_d;
  logic          ack_d;
  logic          fr_d;
  logic [DW-1:0] sreg;
  logic [3:0]    bit_cnt;
  logic [DW-1:0] mem [DEPTH];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;
  logic          par_err;
  logic          overrun;
  logic          frame_err;

  logic          stb_ev;
  logic          ack_ev;
  logic          fr_rise;
  logic          fr_fall;
  logic          capture;
  logic          bit_in;
  logic [DW-1:0] shifted;
  logic          push;
  logic          push_ok;
  logic          pop;
  logic          par_bad;
  logic [DW-1:0] push_data;
  logic          unused_ok;

  assign unused_ok = &{1'b0, uio_in};

  for (genvar i = 0; i < 8; i++) begin : g_sync
    sync2 u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (ui_in[i]),
      .q    (s[i])
    );
  end

  // Edge events, next shift value, push/pop decisions
  always_comb begin
    stb_ev    = s[UI_SSTROBE] & ~stb_d;
    ack_ev    = s[UI_RD_ACK] & ~ack_d;
    fr_rise   = s[UI_SFRAME] & ~fr_d;
    fr_fall   = ~s[UI_SFRAME] & fr_d;
    capture   = stb_ev & s[UI_SFRAME] & ~fr_rise;
    bit_in    = s[UI_SDATA];
    shifted   = (s[UI_DIR] == DIR_LSB) ? {bit_in, sreg[DW-1:1]}
                                       : {sreg[DW-2:0], bit_in};
    push      = 1'b0;
    par_bad   = 1'b0;
    push_data = shifted;
    if (capture) begin
      if (bit_cnt == 4'd8) begin
        push_data = sreg;
        if ((^sreg ^ bit_in) == s[UI_PAR_ODD]) push = 1'b1;
        else par_bad = 1'b1;
      end else if (bit_cnt == 4'd7 && !s[UI_PAR_EN]) begin
        push = 1'b1;
      end
    end
    pop     = ack_ev & (count != 2'd0);
    push_ok = push & ((count != CNT_FULL) | pop);
  end

  // Assembly, FIFO and sticky flag state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_d     <= 1'b0;
      ack_d     <= 1'b0;
      fr_d      <= 1'b0;
      sreg      <= '0;
      bit_cnt   <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= '0;
      par_err   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (ena) begin
      stb_d <= s[UI_SSTROBE];
      ack_d <= s[UI_RD_ACK];
      fr_d  <= s[UI_SFRAME];
      if (s[UI_CLR]) begin
        sreg      <= '0;
        bit_cnt   <= '0;
        rd_ptr    <= 1'b0;
        wr_ptr    <= 1'b0;
        count     <= '0;
        par_err   <= 1'b0;
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end else begin
        if (fr_rise) begin
          bit_cnt <= '0;
          sreg    <= '0;
        end else if (fr_fall) begin
          if (bit_cnt != 4'd0) frame_err <= 1'b1;
          bit_cnt <= '0;
          sreg    <= '0;
        end else if (capture) begin
          if (bit_cnt == 4'd8) begin
            bit_cnt <= '0;
            sreg    <= '0;
            if (par_bad) par_err <= 1'b1;
          end else if (bit_cnt == 4'd7 && !s[UI_PAR_EN]) begin
            bit_cnt <= '0;
            sreg    <= '0;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            sreg    <= shifted;
          end
        end
        if (pop) rd_ptr <= ~rd_ptr;
        if (push_ok) begin
          mem[wr_ptr] <= push_data;
          wr_ptr      <= ~wr_ptr;
        end else if (push) begin
          overrun <= 1'b1;
        end
        unique case ({push_ok, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  // Output pin mapping
  always_comb begin
    uo_out                     = (count != 2'd0) ? mem[rd_ptr] : 8'h00;
    uio_out                    = 8'h00;
    uio_out[UO_VALID]          = count != 2'd0;
    uio_out[UO_FULL]           = count == CNT_FULL;
    uio_out[UO_PAR_ERR]        = par_err;
    uio_out[UO_OVERRUN]        = overrun;
    uio_out[UO_FRAME_ERR]      = frame_err;
    uio_out[UO_BIT_CNT +: 3]   = bit_cnt[2:0];
    uio_oe                     = 8'hFF;
  end

endmodule

// File: tb/tb_tt_um_serial_deserializer.sv
// Self-checking bench for tt_um_serial_deserializer:
// vector table plus directed multi-cycle sequences.
module tb_tt_um_serial_deserializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests = 0;
  int fails = 0;
  logic [7:0] sb [$];

  typedef struct {
    logic       dir;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [5];

  tt_um_serial_deserializer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic with_ack);
    ui_in[0] = b;
    ui_in[1] = 1'b1;
    ui_in[5] = with_ack;
    tick(4);
    ui_in[1] = 1'b0;
    ui_in[5] = 1'b0;
    tick(4);
  endtask

  // bits in wire order for the chosen direction
  task automatic send_data(input logic [7:0] d, input logic dir,
                           input int nbits);
    ui_in[2] = dir;
    for (int i = 0; i < nbits; i++)
      send_bit(dir ? d[i] : d[7-i], 1'b0);
  endtask

  // model of a good byte arriving at the FIFO
  task automatic model_push(input logic [7:0] d);
    if (sb.size() < 2) sb.push_back(d);
  endtask

  task automatic pop_check(input string name);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty, uo_out %02h", name, uo_out);
    end else begin
      check(name, uo_out, sb.pop_front());
    end
    ui_in[5] = 1'b1;
    tick(4);
    ui_in[5] = 1'b0;
    tick(4);
  endtask

  task automatic pulse_clr();
    ui_in[6] = 1'b1;
    tick(4);
    ui_in[6] = 1'b0;
    tick(4);
    sb.delete();
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'hA5, 8'hA5};
    vecs[1] = '{1'b1, 8'hA5, 8'hA5};
    vecs[2] = '{1'b0, 8'h3C, 8'h3C};
    vecs[3] = '{1'b1, 8'h81, 8'h81};
    vecs[4] = '{1'b0, 8'h00, 8'h00};

    tick(2);
    check("reset_uo", uo_out, 8'h00);
    check("reset_uio", uio_out, 8'h00);
    check("reset_oe", uio_oe, 8'hFF);
    rst_n = 1'b1;
    ui_in[7] = 1'b1;
    tick(6);

    for (int i = 0; i < 5; i++) begin
      send_data(vecs[i].data, vecs[i].dir, 8);
      sb.push_back(vecs[i].exp);
      tick(2);
      check("vec_valid", {7'd0, uio_out[0]}, 8'h01);
      check("vec_full", {7'd0, uio_out[1]}, 8'h00);
      pop_check("vec_data");
      check("vec_empty_valid", {7'd0, uio_out[0]}, 8'h00);
      check("vec_empty_uo", uo_out, 8'h00);
    end

    ui_in[3] = 1'b1;
    ui_in[4] = 1'b0;
    send_data(8'h0F, 1'b0, 8);
    check("par_cnt8", {5'd0, uio_out[7:5]}, 8'h00);
    send_bit(1'b1, 1'b0);
    tick(2);
    check("par_err_set", {7'd0, uio_out[2]}, 8'h01);
    check("par_bad_valid", {7'd0, uio_out[0]}, 8'h00);
    send_data(8'h0F, 1'b0, 8);
    send_bit(1'b0, 1'b0);
    model_push(8'h0F);
    tick(2);
    check("par_good_valid", {7'd0, uio_out[0]}, 8'h01);
    pop_check("par_good_data");
    ui_in[4] = 1'b1;
    send_data(8'h07, 1'b1, 8);
    send_bit(1'b0, 1'b0);
    model_push(8'h07);
    tick(2);
    pop_check("par_odd_data");
    ui_in[3] = 1'b0;
    ui_in[4] = 1'b0;
    pulse_clr();
    check("clr_flags", {5'd0, uio_out[4:2]}, 8'h00);

    send_data(8'h44, 1'b0, 8);
    model_push(8'h44);
    send_data(8'h55, 1'b1, 8);
    model_push(8'h55);
    tick(2);
    check("sim_full", {7'd0, uio_out[1]}, 8'h01);
    check("sim_head", uo_out, 8'h44);
    send_data(8'h66, 1'b0, 7);
    send_bit(1'b0, 1'b1);
    void'(sb.pop_front());
    sb.push_back(8'h66);
    tick(2);
    check("sim_full2", {7'd0, uio_out[1]}, 8'h01);
    check("sim_ovr", {7'd0, uio_out[3]}, 8'h00);
    pop_check("sim_head2");
    pop_check("sim_tail");

    send_data(8'h11, 1'b0, 8);
    model_push(8'h11);
    send_data(8'h22, 1'b0, 8);
    model_push(8'h22);
    send_data(8'h33, 1'b0, 8);
    model_push(8'h33);
    tick(2);
    check("ovr_full", {7'd0, uio_out[1]}, 8'h01);
    check("ovr_flag", {7'd0, uio_out[3]}, 8'h01);
    pop_check("ovr_head");
    check("ovr_full_after", {7'd0, uio_out[1]}, 8'h00);
    pop_check("ovr_second");
    check("ovr_drained", {7'd0, uio_out[0]}, 8'h00);
    pulse_clr();

    send_data(8'hF0, 1'b0, 4);
    check("frm_cnt4", {5'd0, uio_out[7:5]}, 8'h04);
    ui_in[7] = 1'b0;
    tick(6);
    check("frm_err", {7'd0, uio_out[4]}, 8'h01);
    check("frm_cnt0", {5'd0, uio_out[7:5]}, 8'h00);
    check("frm_valid", {7'd0, uio_out[0]}, 8'h00);
    pulse_clr();
    check("frm_clr", {5'd0, uio_out[4:2]}, 8'h00);
    ui_in[7] = 1'b1;
    tick(6);

    ena = 1'b0;
    send_data(8'h5A, 1'b0, 8);
    tick(2);
    check("ena_hold_valid", {7'd0, uio_out[0]}, 8'h00);
    check("ena_hold_cnt", {5'd0, uio_out[7:5]}, 8'h00);
    ena = 1'b1;
    tick(4);

    send_data(8'hFF, 1'b0, 5);
    check("rst_cnt5", {5'd0, uio_out[7:5]}, 8'h05);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_uo", uo_out, 8'h00);
    check("rst_mid_uio", uio_out, 8'h00);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    send_data(8'h3C, 1'b0, 8);
    model_push(8'h3C);
    tick(2);
    check("rst_after_valid", {7'd0, uio_out[0]}, 8'h01);
    pop_check("rst_after_data");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
